// File: rtl/dispatch_scheduler_if.sv
// Dispatch bundle between the decode/rename register, the reservation stations
// and the credit-based dispatch scheduler.
interface dispatch_scheduler_if;
    logic        flush;
    logic        in_valid_1;
    logic [1:0]  rs_num_1;
    logic        in_valid_2;
    logic [1:0]  rs_num_2;
    logic        rel_alu;
    logic        rel_sfu;
    logic        rel_bru;
    logic        rel_agu;
    logic        disp_fire_1;
    logic        disp_fire_2;
    logic        in_ready;
    logic        half_done;
    logic        credit_err;
    logic [31:0] stall_cnt;

    modport master (
        output flush, in_valid_1, rs_num_1, in_valid_2, rs_num_2,
        output rel_alu, rel_sfu, rel_bru, rel_agu,
        input  disp_fire_1, disp_fire_2, in_ready, half_done, credit_err, stall_cnt
    );

    modport slave (
        input  flush, in_valid_1, rs_num_1, in_valid_2, rs_num_2,
        input  rel_alu, rel_sfu, rel_bru, rel_agu,
        output disp_fire_1, disp_fire_2, in_ready, half_done, credit_err, stall_cnt
    );
endinterface

// File: rtl/dispatch_scheduler.sv
// Credit-based in-order dispatch of a two-slot decode pair into the ALU, SFU,
// BRU and AGU reservation stations, with pair splitting when only slot 1 fits.
module dispatch_scheduler #(
    parameter int ALU_DEPTH = 16,
    parameter int SFU_DEPTH = 8,
    parameter int BRU_DEPTH = 8,
    parameter int AGU_DEPTH = 8,
    parameter int CW        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    dispatch_scheduler_if.slave  bus
);

    localparam int NW = CW + 2;

    typedef enum logic {
        NORMAL = 1'b0,
        HALF   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cred     [4];
    logic [CW-1:0]   cred_nxt [4];
    logic [NW-1:0]   sum      [4];
    logic [1:0]      fires    [4];
    logic [3:0]      over;
    logic [3:0]      rel;
    logic [CW-1:0]   c1;
    logic [CW-1:0]   c2;
    logic [CW-1:0]   need2;
    logic            f1;
    logic            f2;
    logic            ready;
    logic            stall_inc;
    logic            credit_err_q;
    logic [31:0]     stall_q;

    function automatic logic [CW-1:0] depth_of(input logic [1:0] x);
        logic [CW-1:0] d;
        case (x)
            2'd0:    d = CW'(ALU_DEPTH);
            2'd1:    d = CW'(SFU_DEPTH);
            2'd2:    d = CW'(BRU_DEPTH);
            default: d = CW'(AGU_DEPTH);
        endcase
        return d;
    endfunction

    // Clamp an updated credit count to the station depth.
    function automatic logic [CW-1:0] sat_credit(input logic [NW-1:0] val,
                                                 input logic [CW-1:0] depth);
        logic [CW-1:0] r;
        if (val > NW'(depth))
            r = depth;
        else
            r = val[CW-1:0];
        return r;
    endfunction

    assign rel = {bus.rel_agu, bus.rel_bru, bus.rel_sfu, bus.rel_alu};

    always_comb begin
        f1    = 1'b0;
        f2    = 1'b0;
        ready = 1'b0;
        c1    = cred[bus.rs_num_1];
        c2    = cred[bus.rs_num_2];
        // Both slots targeting one station need two free entries.
        need2 = (bus.rs_num_1 == bus.rs_num_2) ? CW'(2) : CW'(1);
        if (state == NORMAL) begin
            f1    = bus.in_valid_1 && (c1 >= CW'(1));
            f2    = bus.in_valid_2 &&
                    (bus.in_valid_1 ? (f1 && (c2 >= need2)) : (c2 >= CW'(1)));
            ready = (!bus.in_valid_1 || f1) && (!bus.in_valid_2 || f2);
        end else begin
            f2    = bus.in_valid_2 && (c2 >= CW'(1));
            ready = !bus.in_valid_2 || f2;
        end
        if (reset || bus.flush) begin
            f1    = 1'b0;
            f2    = 1'b0;
            ready = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (f1 && bus.in_valid_2 && !f2) state_nxt = HALF;
            HALF:    if (f2) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fires[i]    = {1'b0, f1 && (bus.rs_num_1 == 2'(i))} +
                          {1'b0, f2 && (bus.rs_num_2 == 2'(i))};
            sum[i]      = NW'(cred[i]) + NW'(rel[i]) - NW'(fires[i]);
            over[i]     = sum[i] > NW'(depth_of(2'(i)));
            cred_nxt[i] = sat_credit(sum[i], depth_of(2'(i)));
        end
    end

    assign stall_inc = (bus.in_valid_1 || bus.in_valid_2) && !ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= NORMAL;
            credit_err_q <= 1'b0;
            stall_q      <= '0;
            for (int i = 0; i < 4; i++) cred[i] <= depth_of(2'(i));
        end else if (bus.flush) begin
            // Releases in the flush cycle are dropped: every station is empty.
            state <= NORMAL;
            for (int i = 0; i < 4; i++) cred[i] <= depth_of(2'(i));
        end else begin
            state        <= state_nxt;
            credit_err_q <= credit_err_q | (|over);
            stall_q      <= stall_q + {31'd0, stall_inc};
            for (int i = 0; i < 4; i++) cred[i] <= cred_nxt[i];
        end
    end

    assign bus.disp_fire_1 = f1;
    assign bus.disp_fire_2 = f2;
    assign bus.in_ready    = ready;
    assign bus.half_done   = (state == HALF) && !reset;
    assign bus.credit_err  = credit_err_q;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: directed pairs checked every cycle against a
// credit/queue model, plus hand-computed literal expectations.
module tb_dispatch_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dispatch_scheduler_if bus();

    dispatch_scheduler #(
        .ALU_DEPTH(16), .SFU_DEPTH(8), .BRU_DEPTH(8), .AGU_DEPTH(8), .CW(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int          depth_m [4] = '{16, 8, 8, 8};
    int          mcred   [4] = '{16, 8, 8, 8};
    int          ncred   [4] = '{16, 8, 8, 8};
    bit          mhalf = 1'b0, nhalf = 1'b0;
    bit          merr  = 1'b0, nerr  = 1'b0;
    logic [31:0] mstall = '0, nstall = '0;

    int          av [4];
    bit          e1, e2, rdy;
    int          n;
    logic [3:0]  rl;
    int          s0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: slots claim free entries in program order.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_fire1", bus.disp_fire_1, 0);
            chk("rst_fire2", bus.disp_fire_2, 0);
            chk("rst_ready", bus.in_ready, 0);
            chk("rst_half",  bus.half_done, 0);
            chk("rst_err",   bus.credit_err, 0);
            chk("rst_stall", bus.stall_cnt, 0);
            for (int x = 0; x < 4; x++) ncred[x] = depth_m[x];
            nhalf = 0; nerr = 0; nstall = '0;
        end else begin
            chk("half_done",  bus.half_done, mhalf);
            chk("credit_err", bus.credit_err, merr);
            chk("stall_cnt",  bus.stall_cnt, mstall);
            e1 = 0; e2 = 0; rdy = 0;
            nerr = merr; nstall = mstall; nhalf = mhalf;
            if (bus.flush) begin
                for (int x = 0; x < 4; x++) ncred[x] = depth_m[x];
                nhalf = 0;
            end else begin
                for (int x = 0; x < 4; x++) av[x] = mcred[x];
                if (!mhalf && bus.in_valid_1 && av[bus.rs_num_1] > 0) begin
                    e1 = 1;
                    av[bus.rs_num_1]--;
                end
                if (bus.in_valid_2 && (mhalf || !bus.in_valid_1 || e1) && av[bus.rs_num_2] > 0)
                    e2 = 1;
                rdy = (mhalf || !bus.in_valid_1 || e1) && (!bus.in_valid_2 || e2);
                rl = {bus.rel_agu, bus.rel_bru, bus.rel_sfu, bus.rel_alu};
                for (int x = 0; x < 4; x++) begin
                    n = av[x] + int'(rl[x]) - ((e2 && bus.rs_num_2 == 2'(x)) ? 1 : 0);
                    if (n > depth_m[x]) begin
                        n = depth_m[x];
                        nerr = 1;
                    end
                    ncred[x] = n;
                end
                if (!mhalf) nhalf = e1 && bus.in_valid_2 && !e2;
                else        nhalf = !e2;
                if ((bus.in_valid_1 || bus.in_valid_2) && !rdy) nstall = mstall + 1;
            end
            chk("disp_fire_1", bus.disp_fire_1, e1);
            chk("disp_fire_2", bus.disp_fire_2, e2);
            chk("in_ready",    bus.in_ready, rdy);
        end
    end

    always @(posedge clk) begin
        for (int x = 0; x < 4; x++) mcred[x] <= ncred[x];
        mhalf  <= nhalf;
        merr   <= nerr;
        mstall <= nstall;
    end

    task automatic apply(input logic a, input logic [1:0] ra, input logic b,
                         input logic [1:0] rb, input logic [3:0] r, input logic fl);
        bus.in_valid_1 = a;
        bus.rs_num_1   = ra;
        bus.in_valid_2 = b;
        bus.rs_num_2   = rb;
        bus.rel_alu    = r[0];
        bus.rel_sfu    = r[1];
        bus.rel_bru    = r[2];
        bus.rel_agu    = r[3];
        bus.flush      = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(0, 0, 0, 0, 4'b0000, 0);
        adv();
        apply(0, 0, 0, 0, 4'b0000, 0);
        adv();
        reset = 1'b0;

        // Fresh pair into the ALU: both fire, ALU 16 -> 14.
        apply(1, 0, 1, 0, 4'b0000, 0);
        chk("t1_f1", bus.disp_fire_1, 1);
        chk("t1_f2", bus.disp_fire_2, 1);
        chk("t1_ready", bus.in_ready, 1);
        adv();
        chk("t1_alu_cred", mcred[0], 14);

        // Drain SFU to one credit, then split an SFU pair.
        for (int k = 0; k < 3; k++) begin apply(1, 1, 1, 1, 4'b0000, 0); adv(); end
        apply(1, 1, 0, 0, 4'b0000, 0);
        adv();
        chk("t2_sfu_cred", mcred[1], 1);
        apply(1, 1, 1, 1, 4'b0000, 0);
        chk("t2_c0_f1", bus.disp_fire_1, 1);
        chk("t2_c0_f2", bus.disp_fire_2, 0);
        chk("t2_c0_ready", bus.in_ready, 0);
        adv();
        chk("t2_c0_half", bus.half_done, 1);
        apply(1, 1, 1, 1, 4'b0010, 0);
        chk("t2_c1_f1", bus.disp_fire_1, 0);
        chk("t2_c1_f2", bus.disp_fire_2, 0);
        adv();
        apply(1, 1, 1, 1, 4'b0000, 0);
        chk("t2_c2_f2", bus.disp_fire_2, 1);
        chk("t2_c2_ready", bus.in_ready, 1);
        adv();
        chk("t2_c2_half", bus.half_done, 0);

        // BRU exhausted: a BRU,ALU pair stalls until the release lands.
        for (int k = 0; k < 4; k++) begin apply(1, 2, 1, 2, 4'b0000, 0); adv(); end
        s0 = mstall;
        for (int k = 0; k < 3; k++) begin
            apply(1, 2, 1, 0, 4'b0000, 0);
            chk("t3_stall_f1", bus.disp_fire_1, 0);
            chk("t3_stall_f2", bus.disp_fire_2, 0);
            adv();
        end
        apply(1, 2, 1, 0, 4'b0100, 0);
        chk("t3_relcyc_f1", bus.disp_fire_1, 0);
        adv();
        chk("t3_stall_model", mstall, s0 + 4);
        chk("t3_stall_dut", bus.stall_cnt, s0 + 4);
        apply(1, 2, 1, 0, 4'b0000, 0);
        chk("t3_go_f1", bus.disp_fire_1, 1);
        chk("t3_go_f2", bus.disp_fire_2, 1);
        adv();

        // Release into a full AGU saturates and latches the error flag.
        apply(0, 0, 0, 0, 4'b1000, 0);
        adv();
        chk("t4_err", bus.credit_err, 1);
        chk("t4_agu_cred", mcred[3], 8);
        apply(0, 0, 0, 0, 4'b0000, 0);
        adv();
        chk("t4_err_sticky", bus.credit_err, 1);

        // ALU 13 -> 4, split ALU,SFU into HALF with ALU at 3, then flush.
        for (int k = 0; k < 4; k++) begin apply(1, 0, 1, 0, 4'b0000, 0); adv(); end
        apply(1, 0, 0, 0, 4'b0000, 0);
        adv();
        apply(1, 0, 1, 1, 4'b0000, 0);
        chk("t5_split_f1", bus.disp_fire_1, 1);
        adv();
        chk("t5_alu_cred", mcred[0], 3);
        chk("t5_half", bus.half_done, 1);
        apply(1, 0, 1, 1, 4'b0001, 1);
        chk("t5_flush_f1", bus.disp_fire_1, 0);
        chk("t5_flush_f2", bus.disp_fire_2, 0);
        chk("t5_flush_ready", bus.in_ready, 0);
        adv();
        chk("t5_alu_full", mcred[0], 16);
        apply(0, 0, 0, 0, 4'b0000, 0);
        chk("t5_normal", bus.half_done, 0);
        adv();

        // AGU to one credit; ALU,AGU pair with both releases nets out.
        for (int k = 0; k < 3; k++) begin apply(1, 3, 1, 3, 4'b0000, 0); adv(); end
        apply(1, 3, 0, 0, 4'b0000, 0);
        adv();
        apply(1, 0, 1, 3, 4'b1001, 0);
        chk("t6_f1", bus.disp_fire_1, 1);
        chk("t6_f2", bus.disp_fire_2, 1);
        adv();
        chk("t6_alu_cred", mcred[0], 16);
        chk("t6_agu_cred", mcred[3], 1);

        // Reset while in HALF returns to NORMAL with full credits.
        apply(1, 3, 1, 3, 4'b0000, 0);
        chk("t7_f2", bus.disp_fire_2, 0);
        adv();
        chk("t7_half", bus.half_done, 1);
        reset = 1'b1;
        apply(1, 3, 1, 3, 4'b0000, 0);
        chk("t7_rst_half", bus.half_done, 0);
        chk("t7_rst_f1", bus.disp_fire_1, 0);
        adv();
        reset = 1'b0;
        apply(1, 3, 1, 3, 4'b0000, 0);
        chk("t7_re_f1", bus.disp_fire_1, 1);
        chk("t7_re_f2", bus.disp_fire_2, 1);
        chk("t7_err_clr", bus.credit_err, 0);
        adv();
        apply(0, 0, 1, 2, 4'b0000, 0);
        chk("t7_slot2_only", bus.disp_fire_2, 1);
        chk("t7_slot2_ready", bus.in_ready, 1);
        adv();
        apply(0, 0, 0, 0, 4'b0000, 0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
